event_trigger_arbiter: RTL and testbench
========================================

EVENT_TRIGGER_ARBITER -- requirements
Module: event_trigger_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of event sources (2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of each per-source drop counter.
REQ-003 SHALL have parameter TS_W, default 16, width of the cycle timestamp.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port src_level  input  N_SRC  per-source event level, sampled at posedge clk.
REQ-007 SHALL have port src_mask  input  N_SRC  per-source enable; 0 ignores src_level.
REQ-008 SHALL have port trig_valid  output  1  trigger record available.
REQ-009 SHALL have port trig_ready  input  1  consumer (Nicotb event bridge) accepts record.
REQ-010 SHALL have port trig_id  output  clog2(N_SRC)  source index of the record.
REQ-011 SHALL have port trig_ts  output  TS_W  timestamp at which the event was captured.
REQ-012 SHALL have port pending  output  N_SRC  per-source captured-not-issued flags.
REQ-013 SHALL have port drop_cnt  output  N_SRC*CNT_W  packed drop counters; source i at bits [i*CNT_W +: CNT_W].
REQ-014 SHALL have port busy  output  1  trig_valid OR any pending bit.

Function
REQ-015 SHALL keep a free-running TS_W counter ts, +1 each non-reset cycle, wrapping 2^TS_W-1 -> 0.
REQ-016 SHALL treat source i as firing in a cycle when src_level[i]=1 and src_mask[i]=1.
REQ-017 Firing with pending[i]=0: SHALL set pending[i] and capture current ts into slot i.
REQ-018 Firing with pending[i]=1 and slot i not loaded to output this cycle: SHALL keep the original timestamp and increment drop_cnt[i], saturating at 2^CNT_W-1.
REQ-019 Firing in the same cycle slot i loads to output: SHALL re-set pending[i] with the new ts; no drop.
REQ-020 Output stage SHALL be a register (trig_valid, trig_id, trig_ts); load enabled when trig_valid=0 or trig_ready=1.
REQ-021 On load with any pending bit set, SHALL select by round-robin starting at index rr_ptr, load that slot, clear its pending bit, and set rr_ptr to selected+1 (mod N_SRC).
REQ-022 On load with no pending bits, SHALL drive trig_valid=0.
REQ-023 Latency: event sampled at edge k -> pending at edge k -> trig_valid at edge k+1 minimum.
REQ-024 Throughput: with trig_ready held 1, SHALL issue one record per cycle while pending bits remain.
REQ-025 While trig_valid=1 and trig_ready=0, trig_id and trig_ts SHALL be stable.
REQ-026 Clearing src_mask[i] SHALL NOT clear an already-set pending[i]; it is still issued.
REQ-027 Selection SHALL use only registered pending state; an event in the load cycle is not eligible in that cycle.
REQ-028 trig_valid=1 with trig_ready=1 SHALL be the sole condition that retires a record.

Reset
REQ-029 With rst=1 at posedge clk, SHALL set ts=0, pending=0, all drop_cnt=0, rr_ptr=0, trig_valid=0, trig_id=0, trig_ts=0.
REQ-030 Reset mid-operation SHALL discard pending and output records without issuing them; src_level is ignored during reset cycles.
REQ-031 First cycle after rst deassertion SHALL sample src_level normally; busy=0 until an event is captured.

Verification
REQ-032 Single event: ts=5, src_level=4'b0100 one cycle, ready=1 -> next cycle trig_valid=1, trig_id=2, trig_ts=5, then trig_valid=0.
REQ-033 Round-robin: all 4 sources fire once at same cycle, ready=1 -> ids 0,1,2,3 on consecutive cycles; next all-fire burst starts at 0; after partial grant to 1 only, next burst starts at 2.
REQ-034 Backpressure/drop: ready=0, source 1 fires 4 consecutive cycles -> one record held stable, pending[1]=1, drop_cnt[1]=2 (first captured to output, second pending, two dropped); ready=1 -> two records, ts of first and second firing.
REQ-035 Saturation/wrap: CNT_W=2, source 0 fires 6 cycles with ready=0 -> drop_cnt[0]=3 holds; ts run past 2^TS_W-1 -> trig_ts=0 captured correctly.
REQ-036 Mask/simultaneous: src_mask[3]=0 with src_level[3]=1 -> no record; source 0 firing in its own load cycle -> pending[0] stays 1, drop_cnt[0] unchanged.
REQ-037 Reset mid-operation: 3 pending plus valid record, rst=1 one cycle -> all outputs zero next cycle, no record issued after.

Source files
------------

// File: rtl/event_trigger_arbiter.sv
// Event trigger arbiter.
// Captures masked event levels into per-source pending slots with a timestamp.
// Pending slots are issued through a registered valid/ready output stage in
// round-robin order. Repeat events on an already-pending source are counted
// as drops, and the drop counters saturate.
module event_trigger_arbiter #(
  parameter int N_SRC = 4,
  parameter int CNT_W = 8,
  parameter int TS_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC-1:0]       src_level,
  input  logic [N_SRC-1:0]       src_mask,
  output logic                   trig_valid,
  input  logic                   trig_ready,
  output logic [$clog2(N_SRC)-1:0] trig_id,
  output logic [TS_W-1:0]        trig_ts,
  output logic [N_SRC-1:0]       pending,
  output logic [N_SRC*CNT_W-1:0] drop_cnt,
  output logic                   busy
);

  localparam int ID_W = $clog2(N_SRC);

  logic [TS_W-1:0]  r_ts;
  logic [ID_W-1:0]  r_rr_ptr;
  logic             r_valid;
  logic [ID_W-1:0]  r_id;
  logic [TS_W-1:0]  r_out_ts;

  logic [N_SRC-1:0] w_fire;
  logic [N_SRC-1:0] w_take;
  logic [N_SRC-1:0] w_pending;
  logic [TS_W-1:0]  w_slot_ts [N_SRC];
  logic             w_load;
  logic             w_any;
  logic [ID_W-1:0]  w_sel;
  logic [ID_W-1:0]  w_rr_next;

  // Free-running timestamp, wraps naturally at 2^TS_W.
  always_ff @(posedge clk) begin
    if (rst) r_ts <= '0;
    else     r_ts <= r_ts + 1'b1;
  end

  // The output register may take a new record when empty or being retired.
  assign w_load = ~r_valid | trig_ready;
  assign w_any  = |w_pending;

  // Round-robin pick over registered pending bits, starting at r_rr_ptr.
  // Scanning from the farthest offset down lets the nearest hit win.
  always_comb begin
    logic [ID_W:0] v_idx;
    w_sel = '0;
    v_idx = '0;
    for (int off = N_SRC - 1; off >= 0; off--) begin
      v_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(off);
      if (v_idx >= (ID_W+1)'(N_SRC)) v_idx = v_idx - (ID_W+1)'(N_SRC);
      if (w_pending[v_idx[ID_W-1:0]]) w_sel = v_idx[ID_W-1:0];
    end
  end

  assign w_rr_next = (w_sel == ID_W'(N_SRC - 1)) ? '0 : w_sel + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      logic             r_pend;
      logic [TS_W-1:0]  r_slot;
      logic [CNT_W-1:0] r_drop;

      assign w_fire[gi] = src_level[gi] & src_mask[gi];
      assign w_take[gi] = w_load & w_any & (w_sel == ID_W'(gi));

      // Slot capture: a new event is accepted when the slot is free or is
      // being handed to the output this cycle; otherwise it is a drop.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_pend <= 1'b0;
          r_slot <= '0;
          r_drop <= '0;
        end else if (w_fire[gi] && (!r_pend || w_take[gi])) begin
          r_pend <= 1'b1;
          r_slot <= r_ts;
        end else if (w_fire[gi]) begin
          if (r_drop != {CNT_W{1'b1}}) r_drop <= r_drop + 1'b1;
        end else if (w_take[gi]) begin
          r_pend <= 1'b0;
        end
      end

      assign w_pending[gi]                 = r_pend;
      assign w_slot_ts[gi]                 = r_slot;
      assign drop_cnt[gi*CNT_W +: CNT_W]   = r_drop;
    end
  endgenerate

  // Output record register and round-robin pointer advance on each grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_out_ts <= '0;
      r_rr_ptr <= '0;
    end else if (w_load) begin
      r_valid <= w_any;
      if (w_any) begin
        r_id     <= w_sel;
        r_out_ts <= w_slot_ts[w_sel];
        r_rr_ptr <= w_rr_next;
      end
    end
  end

  assign trig_valid = r_valid;
  assign trig_id    = r_id;
  assign trig_ts    = r_out_ts;
  assign pending    = w_pending;
  assign busy       = r_valid | w_any;

endmodule

// File: tb/tb_event_trigger_arbiter.sv
// Bench for event_trigger_arbiter: expected records are queued as events are
// driven and compared when the DUT retires them on valid && ready.
module tb_event_trigger_arbiter;

  localparam int N_SRC = 4;
  localparam int CNT_W = 2;
  localparam int TS_W  = 8;

  typedef struct packed {
    logic [1:0]      id;
    logic [TS_W-1:0] ts;
  } rec_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_SRC-1:0]       src_level;
  logic [N_SRC-1:0]       src_mask;
  logic                   trig_valid;
  logic                   trig_ready;
  logic [1:0]             trig_id;
  logic [TS_W-1:0]        trig_ts;
  logic [N_SRC-1:0]       pending;
  logic [N_SRC*CNT_W-1:0] drop_cnt;
  logic                   busy;

  int n_checks = 0;
  int n_errors = 0;
  rec_t exp_q[$];
  logic [TS_W-1:0] tb_ts;

  event_trigger_arbiter #(.N_SRC(N_SRC), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
    .clk(clk), .rst(rst), .src_level(src_level), .src_mask(src_mask),
    .trig_valid(trig_valid), .trig_ready(trig_ready), .trig_id(trig_id),
    .trig_ts(trig_ts), .pending(pending), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference timestamp: equals the DUT's current ts between edges.
  always @(posedge clk) begin
    if (rst) tb_ts <= '0;
    else     tb_ts <= tb_ts + 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard and hold-stability monitor, sampled mid-cycle.
  logic            prev_hold = 1'b0;
  logic            prev_rst  = 1'b1;
  logic [1:0]      prev_id;
  logic [TS_W-1:0] prev_ts;
  always @(negedge clk) begin
    rec_t r;
    if (prev_hold && !prev_rst) begin
      chk("hold_id", 32'(trig_id), 32'(prev_id));
      chk("hold_ts", 32'(trig_ts), 32'(prev_ts));
    end
    if (!rst && trig_valid && trig_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", 32'(trig_valid), 32'd0);
      end else begin
        r = exp_q.pop_front();
        chk("sb_id", 32'(trig_id), 32'(r.id));
        chk("sb_ts", 32'(trig_ts), 32'(r.ts));
        $display("record id=%0d ts=%0d", trig_id, trig_ts);
      end
    end
    prev_hold = trig_valid && !trig_ready;
    prev_rst  = rst;
    prev_id   = trig_id;
    prev_ts   = trig_ts;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cycle(input logic [N_SRC-1:0] lv);
    src_level = lv;
    tick();
    src_level = '0;
  endtask

  task automatic push(input int id, input logic [TS_W-1:0] ts);
    rec_t r;
    r.id = 2'(id);
    r.ts = ts;
    exp_q.push_back(r);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_ts(input logic [TS_W-1:0] target);
    int n;
    n = 0;
    while (tb_ts != target && n < 600) begin
      tick();
      n++;
    end
    if (n >= 600) chk("wait_ts_timeout", 32'(tb_ts), 32'(target));
  endtask

  task automatic burst(input int first);
    logic [TS_W-1:0] t;
    t = tb_ts;
    for (int k = 0; k < N_SRC; k++) push((first + k) % N_SRC, t);
    drive_cycle(4'hF);
    chk("burst_pending", 32'(pending), 32'hF);
    for (int k = 0; k < N_SRC; k++) begin
      tick();
      chk("burst_valid", 32'(trig_valid), 32'd1);
    end
    tick();
    chk("burst_idle", 32'(trig_valid), 32'd0);
  endtask

  logic [TS_W-1:0] t0, t1, ts0, ta, tb, tc;

  initial begin
    rst = 1'b1; src_level = '0; src_mask = '1; trig_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(trig_valid), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_id", 32'(trig_id), 32'd0);
    chk("rst_ts", 32'(trig_ts), 32'd0);
    rst = 1'b0;

    // Round robin: two full bursts from 0, a lone grant to 1, then burst from 2.
    trig_ready = 1'b1;
    burst(0);
    burst(0);
    push(1, tb_ts);
    drive_cycle(4'b0010);
    wait_drain();
    burst(2);

    // Timestamp wrap: capture at ts 0, then single event at ts 5.
    wait_ts(8'd0);
    push(0, tb_ts);
    drive_cycle(4'b0001);
    tick();
    chk("wrap_valid", 32'(trig_valid), 32'd1);
    chk("wrap_ts", 32'(trig_ts), 32'd0);
    wait_ts(8'd5);
    push(2, tb_ts);
    drive_cycle(4'b0100);
    chk("single_pending", 32'(pending), 32'b0100);
    chk("single_latency", 32'(trig_valid), 32'd0);
    tick();
    chk("single_valid", 32'(trig_valid), 32'd1);
    chk("single_id", 32'(trig_id), 32'd2);
    chk("single_ts", 32'(trig_ts), 32'd5);
    tick();
    chk("single_done", 32'(trig_valid), 32'd0);

    // Masked source produces nothing.
    src_mask = 4'b0111;
    src_level = 4'b1000;
    repeat (3) tick();
    src_level = '0;
    chk("mask_pending", 32'(pending), 32'd0);
    chk("mask_busy", 32'(busy), 32'd0);
    src_mask = '1;

    // Backpressure, drops and saturation.
    trig_ready = 1'b0;
    src_level = 4'b0010;
    t0 = tb_ts; tick();
    t1 = tb_ts; tick(); tick(); tick();
    src_level = '0;
    chk("bp_valid", 32'(trig_valid), 32'd1);
    chk("bp_id", 32'(trig_id), 32'd1);
    chk("bp_ts", 32'(trig_ts), 32'(t0));
    chk("bp_pending", 32'(pending), 32'b0010);
    chk("bp_drop1", 32'(drop_cnt[3:2]), 32'd2);
    src_level = 4'b0010;
    tick(); tick();
    src_level = 4'b0001;
    ts0 = tb_ts;
    repeat (6) tick();
    src_level = '0;
    chk("sat_drop1", 32'(drop_cnt[3:2]), 32'd3);
    chk("sat_drop0", 32'(drop_cnt[1:0]), 32'd3);
    chk("sat_pending", 32'(pending), 32'b0011);
    push(1, t0); push(0, ts0); push(1, t1);
    trig_ready = 1'b1;
    wait_drain();

    // Event on a source in the same cycle its slot moves to the output.
    trig_ready = 1'b0;
    ta = tb_ts; drive_cycle(4'b0100);
    tick();
    tb = tb_ts; drive_cycle(4'b1000);
    push(2, ta); push(3, tb);
    src_level = 4'b1000;
    trig_ready = 1'b1;
    tc = tb_ts;
    push(3, tc);
    tick();
    src_level = '0;
    chk("own_pending", 32'(pending), 32'b1000);
    chk("own_drop3", 32'(drop_cnt[7:6]), 32'd0);
    chk("own_id", 32'(trig_id), 32'd3);
    chk("own_ts", 32'(trig_ts), 32'(tb));
    wait_drain();

    // Reset with three pending slots and a held record.
    trig_ready = 1'b0;
    drive_cycle(4'b0111);
    tick();
    drive_cycle(4'b1000);
    chk("prerst_pending", 32'(pending), 32'b1110);
    chk("prerst_valid", 32'(trig_valid), 32'd1);
    rst = 1'b1;
    src_level = 4'hF;
    tick();
    rst = 1'b0;
    src_level = '0;
    chk("midrst_valid", 32'(trig_valid), 32'd0);
    chk("midrst_pending", 32'(pending), 32'd0);
    chk("midrst_drop", 32'(drop_cnt), 32'd0);
    chk("midrst_id", 32'(trig_id), 32'd0);
    chk("midrst_ts", 32'(trig_ts), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    trig_ready = 1'b1;
    repeat (10) tick();
    chk("postrst_idle", 32'(busy), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
